// File: rtl/pps_mem_port_arb_pkg.sv
// rtl/pps_mem_port_arb_pkg.sv - shared constants and helpers for the memory port arbiter
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif

package pps_mem_port_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Never returns less than 1 so a two-port or one-port index still has a bit.
  function automatic int pps_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pps_rr_pick.sv
// rtl/pps_rr_pick.sv - rotate-priority encoder: first requester at or after ptr wins
module pps_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin : pick
    logic          found;
    logic [IW-1:0] k;
    found = 1'b0;
    k     = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int off = 0; off < N; off++) begin
      k = IW'((int'(ptr_i) + off) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/pps_mem_port_arb.sv
// rtl/pps_mem_port_arb.sv - multiplexes NUM_PORTS requesters onto one single-ported SRAM
module pps_mem_port_arb
  import pps_mem_port_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = ARB_RR,
  parameter int MAX_WAIT   = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] bwe_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             mem_bwe_o,
  output logic                                mem_re_o,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

  localparam int IW = pps_clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 any_gnt;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

  generate
    if (NUM_PORTS == 1) begin : g_single
      assign pick_gnt = req_i;
      assign pick_idx = '0;
    end else if (ARB_MODE == ARB_RR) begin : g_rr
      logic [IW-1:0] ptr_q, ptr_d;

      pps_rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
        .req_i(req_i), .ptr_i(ptr_q), .gnt_o(pick_gnt), .idx_o(pick_idx)
      );

      always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) ptr_d = (pick_idx == IW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
      end
    end else begin : g_fixed
      logic [NUM_PORTS-1:0][7:0] wait_q, wait_d;
      logic [NUM_PORTS-1:0]      starved, s_gnt, n_gnt;
      logic [IW-1:0]             s_idx, n_idx;

      // A port that stopped requesting must not win on a stale counter.
      always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          starved[i] = req_i[i] && (wait_q[i] == 8'(MAX_WAIT));
          if (!req_i[i] || gnt_o[i])            wait_d[i] = '0;
          else if (wait_q[i] != 8'(MAX_WAIT))   wait_d[i] = wait_q[i] + 8'd1;
          else                                  wait_d[i] = wait_q[i];
        end
      end

      pps_rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_starved (
        .req_i(starved), .ptr_i('0), .gnt_o(s_gnt), .idx_o(s_idx)
      );
      pps_rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick_normal (
        .req_i(req_i), .ptr_i('0), .gnt_o(n_gnt), .idx_o(n_idx)
      );

      assign pick_gnt = (|s_gnt) ? s_gnt : n_gnt;
      assign pick_idx = (|s_gnt) ? s_idx : n_idx;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wait_q <= '0;
        else       wait_q <= wait_d;
      end
    end
  endgenerate

  assign gnt_o   = rst_i ? '0 : pick_gnt;
  assign any_gnt = |gnt_o;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_bwe_o   = '0;
    mem_re_o    = 1'b0;
    rvalid_d    = '0;
    if (any_gnt) begin
      mem_addr_o  = addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_o = wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      if (we_i[pick_idx]) begin
        mem_bwe_o = bwe_i[pick_idx*BW +: BW];
      end else begin
        mem_re_o = 1'b1;
        rvalid_d = gnt_o;
      end
    end
  end

  // rvalid doubles as the registered owner of the read in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rvalid_q <= '0;
    else       rvalid_q <= rvalid_d;
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (|rvalid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_pps_mem_port_arb.sv
// tb/tb_pps_mem_port_arb.sv - vector table, corner sequences and randomized scoreboard for pps_mem_port_arb
module tb_pps_mem_port_arb;
  import pps_mem_port_arb_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pre32(input int a);
    return (a == 5) ? 32'h1122_3344 : (32'hA000_0000 | 32'(a));
  endfunction

  function automatic logic [63:0] pre64(input int a);
    return {32'hC0DE_0000 + 32'(a), 32'h5A5A_0000 + 32'(a)};
  endfunction

  // ---------------- instance A: 2 ports, round-robin ----------------
  logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
  logic [15:0] a_addr;
  logic [63:0] a_wdata;
  logic [7:0]  a_bwe;
  logic [31:0] a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0] a_maddr;
  logic [3:0]  a_mbwe;
  logic        a_mre;
  bit [31:0] mem_a [256];
  bit        wr_a  [256];

  function automatic logic [31:0] rd_a(input logic [7:0] ad);
    return wr_a[ad] ? mem_a[ad] : pre32(int'(ad));
  endfunction

  always @(posedge clk) begin
    if (a_mre) a_mrdata <= rd_a(a_maddr);
    if (a_mbwe != 4'h0) begin
      mem_a[a_maddr] <= 32'(merge({32'h0, rd_a(a_maddr)}, {32'h0, a_mwdata}, {4'h0, a_mbwe}));
      wr_a[a_maddr]  <= 1'b1;
    end
  end

  pps_mem_port_arb #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ARB_MODE(ARB_RR), .MAX_WAIT(8)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata),
    .bwe_i(a_bwe), .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .mem_addr_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_bwe_o(a_mbwe), .mem_re_o(a_mre), .mem_rdata_i(a_mrdata)
  );

  // ---------------- instance B: 3 ports, fixed priority, MAX_WAIT 3 ----------------
  logic [2:0]  b_req, b_we, b_gnt, b_rvalid;
  logic [23:0] b_addr;
  logic [95:0] b_wdata;
  logic [11:0] b_bwe;
  logic [31:0] b_rdata, b_mwdata, b_mrdata;
  logic [AW-1:0] b_maddr;
  logic [3:0]  b_mbwe;
  logic        b_mre;
  bit [31:0] mem_b [256];
  bit        wr_b  [256];

  function automatic logic [31:0] rd_b(input logic [7:0] ad);
    return wr_b[ad] ? mem_b[ad] : pre32(int'(ad));
  endfunction

  always @(posedge clk) begin
    if (b_mre) b_mrdata <= rd_b(b_maddr);
    if (b_mbwe != 4'h0) begin
      mem_b[b_maddr] <= 32'(merge({32'h0, rd_b(b_maddr)}, {32'h0, b_mwdata}, {4'h0, b_mbwe}));
      wr_b[b_maddr]  <= 1'b1;
    end
  end

  pps_mem_port_arb #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ARB_MODE(ARB_FIXED), .MAX_WAIT(3)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata),
    .bwe_i(b_bwe), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_bwe_o(b_mbwe), .mem_re_o(b_mre), .mem_rdata_i(b_mrdata)
  );

  // ---------------- instance C: 4 ports, 64-bit, round-robin ----------------
  logic [3:0]   c_req, c_we, c_gnt, c_rvalid;
  logic [31:0]  c_addr;
  logic [255:0] c_wdata;
  logic [31:0]  c_bwe;
  logic [63:0]  c_rdata, c_mwdata, c_mrdata;
  logic [AW-1:0] c_maddr;
  logic [7:0]   c_mbwe;
  logic         c_mre;
  bit [63:0] mem_c [256];
  bit        wr_c  [256];

  function automatic logic [63:0] rd_c(input logic [7:0] ad);
    return wr_c[ad] ? mem_c[ad] : pre64(int'(ad));
  endfunction

  always @(posedge clk) begin
    if (c_mre) c_mrdata <= rd_c(c_maddr);
    if (c_mbwe != 8'h0) begin
      mem_c[c_maddr] <= merge(rd_c(c_maddr), c_mwdata, c_mbwe);
      wr_c[c_maddr]  <= 1'b1;
    end
  end

  pps_mem_port_arb #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(64), .ARB_MODE(ARB_RR), .MAX_WAIT(8)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(c_req), .we_i(c_we), .addr_i(c_addr), .wdata_i(c_wdata),
    .bwe_i(c_bwe), .gnt_o(c_gnt), .rvalid_o(c_rvalid), .rdata_o(c_rdata), .mem_addr_o(c_maddr),
    .mem_wdata_o(c_mwdata), .mem_bwe_o(c_mbwe), .mem_re_o(c_mre), .mem_rdata_i(c_mrdata)
  );

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic [1:0] req, we;
    logic [7:0] a0, a1;
    logic [31:0] wd1;
    logic [3:0] bwe1;
    logic [1:0] gnt;
    logic re;
    logic [3:0] mbwe;
    logic [1:0] rv;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [9];

  logic [2:0] starve_exp [6];

  // reference-model state for the randomized phase
  bit          cp [4], cwe [4];
  logic [7:0]  cad [4], cbe [4];
  logic [63:0] cwd [4];
  logic [63:0] shc [256];
  int          ptr_m, cw;
  logic [3:0]  exp_rv;
  logic [63:0] exp_rd;
  bit          bp [3], bwe_m [3];
  logic [7:0]  bad [3];
  int          bwait [3];
  int          bw_w;

  initial begin
    tbl[0] = '{2'b00, 2'b00, 8'd0, 8'd0, 32'h0,         4'h0, 2'b00, 1'b0, 4'h0, 2'b00, 32'h0};
    tbl[1] = '{2'b11, 2'b00, 8'd2, 8'd3, 32'h0,         4'h0, 2'b01, 1'b1, 4'h0, 2'b00, 32'h0};
    tbl[2] = '{2'b11, 2'b00, 8'd2, 8'd3, 32'h0,         4'h0, 2'b10, 1'b1, 4'h0, 2'b01, 32'hA000_0002};
    tbl[3] = '{2'b11, 2'b00, 8'd2, 8'd3, 32'h0,         4'h0, 2'b01, 1'b1, 4'h0, 2'b10, 32'hA000_0003};
    tbl[4] = '{2'b11, 2'b00, 8'd2, 8'd3, 32'h0,         4'h0, 2'b10, 1'b1, 4'h0, 2'b01, 32'hA000_0002};
    tbl[5] = '{2'b10, 2'b10, 8'd0, 8'd5, 32'hDEAD_BEEF, 4'h3, 2'b10, 1'b0, 4'h3, 2'b10, 32'hA000_0003};
    tbl[6] = '{2'b01, 2'b00, 8'd5, 8'd0, 32'h0,         4'h0, 2'b01, 1'b1, 4'h0, 2'b00, 32'h0};
    tbl[7] = '{2'b00, 2'b00, 8'd0, 8'd0, 32'h0,         4'h0, 2'b00, 1'b0, 4'h0, 2'b01, 32'h1122_BEEF};
    tbl[8] = '{2'b00, 2'b00, 8'd0, 8'd0, 32'h0,         4'h0, 2'b00, 1'b0, 4'h0, 2'b00, 32'h0};
    starve_exp[0] = 3'b001; starve_exp[1] = 3'b001; starve_exp[2] = 3'b001;
    starve_exp[3] = 3'b010; starve_exp[4] = 3'b100; starve_exp[5] = 3'b001;

    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_bwe = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_bwe = '0;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0; c_bwe = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      a_req = tbl[i].req; a_we = tbl[i].we;
      a_addr = {tbl[i].a1, tbl[i].a0};
      a_wdata = {tbl[i].wd1, 32'h0};
      a_bwe = {tbl[i].bwe1, 4'h0};
      #4;
      chk($sformatf("tbl%0d_gnt", i), a_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_mem_re", i), a_mre, tbl[i].re);
      chk($sformatf("tbl%0d_mem_bwe", i), a_mbwe, tbl[i].mbwe);
      chk($sformatf("tbl%0d_rvalid", i), a_rvalid, tbl[i].rv);
      chk($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].rd);
      @(posedge clk); #1;
    end

    // read in flight when an asynchronous reset pulse lands between edges
    a_req = 2'b01; a_we = 2'b00; a_addr = {8'd3, 8'd2};
    #4 chk("rst_pre_gnt", a_gnt, 2'b01);
    @(posedge clk); #1;
    a_req = 2'b11;
    rst = 1'b1;
    #1 chk("rst_gnt_forced", a_gnt, 2'b00);
    chk("rst_mem_re_forced", a_mre, 1'b0);
    #1 rst = 1'b0; a_req = 2'b00;
    #1 chk("rst_rvalid_cleared", a_rvalid, 2'b00);
    chk("rst_rdata_cleared", a_rdata, 32'h0);
    @(posedge clk); #1;
    a_req = 2'b11;
    #4 chk("rst_tie_port0", a_gnt, 2'b01);
    @(posedge clk); #1;
    a_req = 2'b00;
    #4 chk("rst_next_rvalid", a_rvalid, 2'b01);
    chk("rst_next_rdata", a_rdata, 32'hA000_0002);
    @(posedge clk); #1;

    // starvation guard on instance B
    b_req = 3'b111; b_we = 3'b000; b_addr = {8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 6; i++) begin
      #4 chk($sformatf("starve%0d_gnt", i), b_gnt, starve_exp[i]);
      @(posedge clk); #1;
    end
    b_req = 3'b000;
    @(posedge clk); #1;

    // randomized phase: C against a round-robin scoreboard, B against a priority/age model
    for (int a = 0; a < 256; a++) shc[a] = pre64(a);
    for (int p = 0; p < 4; p++) cp[p] = 1'b0;
    for (int p = 0; p < 3; p++) begin bp[p] = 1'b0; bwait[p] = 0; end
    ptr_m = 0; exp_rv = '0; exp_rd = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        if (!cp[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            cp[p] = 1'b1;
            cwe[p] = ($urandom_range(0, 2) == 0);
            cad[p] = 8'($urandom_range(0, 15));
            cwd[p] = {$urandom, $urandom};
            cbe[p] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          cp[p] = 1'b0;
        end
        c_req[p] = cp[p]; c_we[p] = cwe[p];
        c_addr[p*AW +: AW] = cad[p];
        c_wdata[p*64 +: 64] = cwd[p];
        c_bwe[p*8 +: 8] = cbe[p];
      end
      for (int p = 0; p < 3; p++) begin
        if (!bp[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            bp[p] = 1'b1;
            bwe_m[p] = ($urandom_range(0, 2) == 0);
            bad[p] = 8'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bp[p] = 1'b0;
        end
        b_req[p] = bp[p]; b_we[p] = bwe_m[p];
        b_addr[p*AW +: AW] = bad[p];
        b_wdata[p*32 +: 32] = $urandom;
        b_bwe[p*4 +: 4] = 4'($urandom);
      end
      #4;

      cw = -1;
      for (int o = 0; o < 4; o++) begin
        int k;
        k = (ptr_m + o) % 4;
        if (cw < 0 && cp[k]) cw = k;
      end
      chk("c_gnt", c_gnt, (cw < 0) ? 64'd0 : 64'(1 << cw));
      chk("c_gnt_onehot0", 64'($onehot0(c_gnt)), 64'd1);
      chk("c_rvalid", c_rvalid, exp_rv);
      chk("c_rdata", c_rdata, (exp_rv != 4'h0) ? exp_rd : 64'd0);
      if (cw < 0) begin
        chk("c_mem_idle", {c_mre, c_mbwe}, 64'd0);
      end else begin
        chk("c_mem_addr", c_maddr, cad[cw]);
        chk("c_mem_re", c_mre, !cwe[cw]);
        chk("c_mem_bwe", c_mbwe, cwe[cw] ? cbe[cw] : 8'h0);
      end

      bw_w = -1;
      for (int p = 0; p < 3; p++) if (bw_w < 0 && bp[p] && bwait[p] == 3) bw_w = p;
      for (int p = 0; p < 3; p++) if (bw_w < 0 && bp[p]) bw_w = p;
      chk("b_gnt", b_gnt, (bw_w < 0) ? 64'd0 : 64'(1 << bw_w));

      exp_rv = '0;
      if (cw >= 0) begin
        ptr_m = (cw + 1) % 4;
        if (cwe[cw]) begin
          shc[cad[cw]] = merge(shc[cad[cw]], cwd[cw], cbe[cw]);
        end else begin
          exp_rv = 4'(1 << cw);
          exp_rd = shc[cad[cw]];
        end
        cp[cw] = 1'b0;
      end
      for (int p = 0; p < 3; p++) begin
        if (!bp[p] || p == bw_w) bwait[p] = 0;
        else if (bwait[p] < 3)   bwait[p]++;
      end
      if (bw_w >= 0) bp[bw_w] = 1'b0;
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
